// File: rtl/shift_sequencer.sv
// Multi-step shift controller: latches one request, then applies the selected
// one-bit shift 'amount' times, one step per clock, and pulses done with the result.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  // state   | meaning
  // S_IDLE  | waiting for start, dout holds last result
  // S_SHIFT | stepping the working register, cnt = steps remaining
  // S_DONE  | one-cycle result strobe, may accept a new start
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a, input logic [2:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      3'b000:  r = {a[WIDTH-2:0], 1'b0};
      3'b001:  r = {a[WIDTH-2:0], 1'b1};
      3'b010:  r = {1'b0, a[WIDTH-1:1]};
      3'b011:  r = {1'b1, a[WIDTH-1:1]};
      3'b100:  r = {a[WIDTH-2:0], 1'b0};
      3'b101:  r = {a[WIDTH-1], a[WIDTH-1:1]};
      3'b110:  r = {a[WIDTH-2:0], a[WIDTH-1]};
      default: r = {a[0], a[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode;
          dout_d  = din;
          cnt_d   = amount;
          state_d = (amount == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        dout_d = step(dout_q, mode_q);
        cnt_d  = cnt_q - CNT_W'(1);
        // last step: terminal count reached on this edge
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against a closed-form
// model of multi-bit shifts (whole shift computed at once, not stepped).
module tb_shift_sequencer;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mode;
  logic [3:0] din;
  logic [2:0] amount;
  logic       busy;
  logic       done;
  logic [3:0] dout;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .din    (din),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [3:0] a, input logic [2:0] m, input int n);
    int v, mask, s, rr, r, hi_fill;
    v       = int'(a);
    mask    = (1 << W) - 1;
    s       = (n > W) ? W : n;
    rr      = n % W;
    hi_fill = mask & ~(mask >> s);
    case (m)
      3'd0, 3'd4: r = (v << s) & mask;
      3'd1:       r = ((v << s) | ((1 << s) - 1)) & mask;
      3'd2:       r = v >> s;
      3'd3:       r = (v >> s) | hi_fill;
      3'd5:       r = a[W-1] ? ((v >> s) | hi_fill) : (v >> s);
      3'd6:       r = ((v << rr) | (v >> (W - rr))) & mask;
      default:    r = ((v >> rr) | (v << (W - rr))) & mask;
    endcase
    return 4'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one step after a clock edge; returns in the DONE cycle with start low.
  task automatic req(input logic [3:0] d, input logic [2:0] m, input logic [2:0] a, input bit noise);
    logic [3:0] exp;
    exp    = model(d, m, int'(a));
    start  = 1'b1;
    din    = d;
    mode   = m;
    amount = a;
    @(posedge clk); #1;
    start  = 1'b0;
    din    = 4'($urandom);
    mode   = 3'($urandom);
    amount = 3'($urandom);
    for (int i = 0; i < int'(a); i++) begin
      chk("busy_during_shift", busy, 1);
      chk("done_during_shift", done, 0);
      if (noise) begin
        start  = (i == 1) ? 1'b1 : 1'($urandom);
        din    = (i == 1) ? 4'b0000 : 4'($urandom);
        mode   = 3'($urandom);
        amount = 3'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("dout_result", dout, exp);
  endtask

  initial begin
    logic [3:0] last;
    rst    = 1'b1;
    start  = 1'b1;
    din    = 4'b1111;
    mode   = 3'b001;
    amount = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", dout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    req(4'b1001, 3'b101, 3'd2, 1'b0);
    chk("asr2_value", dout, 4'b1110);
    @(posedge clk); #1;
    chk("done_drops", done, 0);
    chk("dout_holds", dout, 4'b1110);

    req(4'b1001, 3'b110, 3'd5, 1'b0);
    chk("rotl5_value", dout, 4'b0011);
    @(posedge clk); #1;

    req(4'b1010, 3'b000, 3'd0, 1'b0);
    chk("amt0_value", dout, 4'b1010);
    @(posedge clk); #1;

    req(4'b0111, 3'b011, 3'd3, 1'b1);
    chk("fill1_right_value", dout, 4'b1110);
    req(4'b0111, 3'b111, 3'd1, 1'b0);
    chk("b2b_rotr_value", dout, 4'b1011);
    @(posedge clk); #1;
    chk("after_b2b_done", done, 0);

    start  = 1'b1;
    din    = 4'b1111;
    mode   = 3'b010;
    amount = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_dout", dout, 0);
    chk("abort_busy_low", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_dout_held", dout, 0);
      @(posedge clk); #1;
    end

    last = 4'b0000;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] d;
      logic [2:0] m;
      logic [2:0] a;
      d = 4'($urandom);
      m = 3'($urandom);
      a = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        chk("rand_idle_done", done, 0);
        chk("rand_idle_busy", busy, 0);
        chk("rand_idle_dout", dout, last);
      end
      req(d, m, a, bit'($urandom_range(0, 1)));
      last = model(d, m, int'(a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
